// File: rtl/sd_defs.sv
// Shared definitions for the SD CMD/DAT line engines: frame geometry,
// CRC7 polynomial, CMD FSM state encoding and the serial CRC7 step function.
package sd_defs;

    localparam int         CMD_FRAME_LEN   = 48;
    localparam logic [6:0] CRC7_POLY       = 7'h09;
    localparam int         NCR_TIMEOUT_DEF = 64;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_SEND = 3'd1,
        ST_WAIT = 3'd2,
        ST_RECV = 3'd3,
        ST_DONE = 3'd4
    } cmd_state_e;

    // One MSB-first step of x^7+x^3+1
    function automatic logic [6:0] crc7_step(input logic [6:0] crc, input logic din);
        logic fb;
        fb = din ^ crc[6];
        return {crc[5:0], 1'b0} ^ (fb ? CRC7_POLY : 7'h00);
    endfunction

endpackage

// File: rtl/crc7.sv
// Serial CRC7 accumulator, one bit per enabled clock; clear has priority over enable.
module crc7
    import sd_defs::*;
(
    input  logic       iclk,
    input  logic       irst,
    input  logic       iclr,
    input  logic       ien,
    input  logic       ibit,
    output logic [6:0] ocrc
);

    logic [6:0] crc_r;

    // CRC register: clear, accumulate or hold
    always_ff @(posedge iclk or posedge irst) begin
        if (irst) begin
            crc_r <= 7'h00;
        end else if (iclr) begin
            crc_r <= 7'h00;
        end else if (ien) begin
            crc_r <= crc7_step(crc_r, ibit);
        end else begin
            crc_r <= crc_r;
        end
    end

    assign ocrc = crc_r;

endmodule

// File: rtl/cmd_driver.sv
// SD CMD-line engine: serialises a 48-bit command with CRC7, then waits for and
// deserialises the card response, reporting payload, CRC/framing error, timeout and done.
module cmd_driver
    import sd_defs::*;
#(
    parameter int NCR_TIMEOUT = NCR_TIMEOUT_DEF
) (
    input  logic        iclk,
    input  logic        irst,
    inout  wire         iocmd_sd,
    input  logic        isend,
    input  logic [5:0]  icmd_index,
    input  logic [31:0] icmd_arg,
    input  logic        iresp_none,
    input  logic        iresp_nocrc,
    output logic [31:0] oresp,
    output logic        ocrc_fail,
    output logic        otimeout,
    output logic        odone
);

    localparam int              TO_W     = $clog2(NCR_TIMEOUT + 1);
    localparam logic [5:0]      LAST_BIT = 6'(CMD_FRAME_LEN - 1);
    localparam logic [5:0]      CRC_BIT  = 6'd39;
    localparam logic [TO_W-1:0] TO_LAST  = TO_W'(NCR_TIMEOUT - 1);
    localparam logic [TO_W-1:0] TO_MAX   = TO_W'(NCR_TIMEOUT);
    localparam logic [TO_W-1:0] TO_ONE   = TO_W'(1);

    cmd_state_e      state_r;
    cmd_state_e      state_nxt_s;
    logic [5:0]      bit_cnt_r;
    logic [TO_W-1:0] to_cnt_r;
    logic [38:0]     tx_sr_r;
    logic [46:0]     rx_sr_r;
    logic            cmd_oe_r;
    logic            cmd_bit_r;
    logic            resp_none_r;
    logic            resp_nocrc_r;
    logic            line_s;
    logic            crc_clr_s;
    logic            crc_en_s;
    logic            crc_bit_s;
    logic [6:0]      crc_s;

    assign iocmd_sd = cmd_oe_r ? cmd_bit_r : 1'bz;
    assign line_s   = iocmd_sd;

    crc7 u_crc7 (
        .iclk (iclk),
        .irst (irst),
        .iclr (crc_clr_s),
        .ien  (crc_en_s),
        .ibit (crc_bit_s),
        .ocrc (crc_s)
    );

    // Next-state and CRC feed control
    always_comb begin
        state_nxt_s = state_r;
        crc_clr_s   = 1'b0;
        crc_en_s    = 1'b0;
        crc_bit_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (isend) begin
                    state_nxt_s = ST_SEND;
                    crc_clr_s   = 1'b1;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SEND: begin
                if (bit_cnt_r == LAST_BIT) begin
                    state_nxt_s = resp_none_r ? ST_DONE : ST_WAIT;
                end else if (bit_cnt_r < CRC_BIT) begin
                    // bit about to be driven is frame bit 1..39
                    crc_en_s  = 1'b1;
                    crc_bit_s = tx_sr_r[38];
                end else begin
                    state_nxt_s = ST_SEND;
                end
            end
            ST_WAIT: begin
                if (bit_cnt_r == 6'd0) begin
                    state_nxt_s = ST_WAIT;
                end else if (!line_s) begin
                    state_nxt_s = ST_RECV;
                    crc_clr_s   = 1'b1;
                end else if (to_cnt_r == TO_LAST) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_WAIT;
                end
            end
            ST_RECV: begin
                if (bit_cnt_r == LAST_BIT) begin
                    state_nxt_s = ST_DONE;
                end else if (bit_cnt_r < CRC_BIT) begin
                    crc_en_s  = 1'b1;
                    crc_bit_s = line_s;
                end else begin
                    state_nxt_s = ST_RECV;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // FSM state register
    always_ff @(posedge iclk or posedge irst) begin
        if (irst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Line driver, shift registers, counters and result outputs
    always_ff @(posedge iclk or posedge irst) begin
        if (irst) begin
            bit_cnt_r    <= 6'd0;
            to_cnt_r     <= '0;
            tx_sr_r      <= 39'd0;
            rx_sr_r      <= 47'd0;
            cmd_oe_r     <= 1'b0;
            cmd_bit_r    <= 1'b1;
            resp_none_r  <= 1'b0;
            resp_nocrc_r <= 1'b0;
            oresp        <= 32'd0;
            ocrc_fail    <= 1'b0;
            otimeout     <= 1'b0;
            odone        <= 1'b0;
        end else begin
            odone <= (state_nxt_s == ST_DONE);
            case (state_r)
                ST_IDLE: begin
                    if (isend) begin
                        // start bit goes out on this edge; the rest follows from tx_sr_r
                        cmd_oe_r     <= 1'b1;
                        cmd_bit_r    <= 1'b0;
                        tx_sr_r      <= {1'b1, icmd_index, icmd_arg};
                        bit_cnt_r    <= 6'd0;
                        resp_none_r  <= iresp_none;
                        resp_nocrc_r <= iresp_nocrc;
                        oresp        <= 32'd0;
                        ocrc_fail    <= 1'b0;
                        otimeout     <= 1'b0;
                    end else begin
                        cmd_oe_r <= 1'b0;
                    end
                end
                ST_SEND: begin
                    if (bit_cnt_r == LAST_BIT) begin
                        cmd_oe_r  <= 1'b0;
                        cmd_bit_r <= 1'b1;
                        bit_cnt_r <= 6'd0;
                        to_cnt_r  <= '0;
                    end else if (bit_cnt_r == CRC_BIT) begin
                        // reload the shifter with the remaining CRC bits and the end bit
                        cmd_bit_r <= crc_s[6];
                        tx_sr_r   <= {crc_s[5:0], 1'b1, 32'd0};
                        bit_cnt_r <= bit_cnt_r + 6'd1;
                    end else begin
                        cmd_bit_r <= tx_sr_r[38];
                        tx_sr_r   <= {tx_sr_r[37:0], 1'b0};
                        bit_cnt_r <= bit_cnt_r + 6'd1;
                    end
                end
                ST_WAIT: begin
                    if (bit_cnt_r == 6'd0) begin
                        bit_cnt_r <= 6'd1;
                    end else if (!line_s) begin
                        bit_cnt_r <= 6'd0;
                        rx_sr_r   <= 47'd0;
                    end else begin
                        if (to_cnt_r != TO_MAX) begin
                            to_cnt_r <= to_cnt_r + TO_ONE;
                        end else begin
                            to_cnt_r <= to_cnt_r;
                        end
                        if (to_cnt_r == TO_LAST) begin
                            otimeout <= 1'b1;
                        end else begin
                            otimeout <= otimeout;
                        end
                    end
                end
                ST_RECV: begin
                    if (bit_cnt_r == LAST_BIT) begin
                        // rx_sr_r[46] is the transmission bit, [0] the end bit
                        oresp     <= rx_sr_r[39:8];
                        ocrc_fail <= ((crc_s != rx_sr_r[7:1]) && !resp_nocrc_r)
                                     || rx_sr_r[46] || !rx_sr_r[0];
                    end else begin
                        rx_sr_r   <= {rx_sr_r[45:0], line_s};
                        bit_cnt_r <= bit_cnt_r + 6'd1;
                    end
                end
                ST_DONE: begin
                    cmd_oe_r <= 1'b0;
                end
                default: begin
                    cmd_oe_r <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cmd_driver.sv
// Directed bench for cmd_driver: a card model on the pulled-up CMD line replies
// with fixed R1/R7 frames; frames, timing and result flags are checked per scenario.
module tb_cmd_driver;

    localparam int NCR = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic        isend;
    logic [5:0]  cmd_index;
    logic [31:0] cmd_arg;
    logic        resp_none;
    logic        resp_nocrc;
    logic [31:0] resp;
    logic        crc_fail;
    logic        timeout;
    logic        done;
    logic        card_oe;
    logic        card_bit;
    wire         cmd_line;

    int n_checks = 0;
    int n_fail   = 0;
    int done_cnt = 0;

    logic [47:0] got_frame;
    logic        rel_line, done_early, done_obs, done_after, crc_obs, to_obs;
    logic [31:0] resp_obs;
    int          pulses;

    pullup pu_cmd (cmd_line);
    assign cmd_line = card_oe ? card_bit : 1'bz;

    always #5 clk = ~clk;

    always @(posedge clk) if (done === 1'b1) done_cnt <= done_cnt + 1;

    cmd_driver #(.NCR_TIMEOUT(NCR)) dut (
        .iclk        (clk),
        .irst        (rst),
        .iocmd_sd    (cmd_line),
        .isend       (isend),
        .icmd_index  (cmd_index),
        .icmd_arg    (cmd_arg),
        .iresp_none  (resp_none),
        .iresp_nocrc (resp_nocrc),
        .oresp       (resp),
        .ocrc_fail   (crc_fail),
        .otimeout    (timeout),
        .odone       (done)
    );

    // Drives one transaction and records what was observed at the defined instants.
    task automatic run_txn(input logic [5:0] idx, input logic [31:0] arg, input logic none,
                           input logic nocrc, input logic silent, input logic [47:0] rsp,
                           input int pulse_bit, input logic pulse_wait);
        int c0;
        c0 = done_cnt;
        @(negedge clk);
        cmd_index = idx; cmd_arg = arg; resp_none = none; resp_nocrc = nocrc; isend = 1'b1;
        @(posedge clk);
        for (int i = 0; i < 48; i++) begin
            @(negedge clk);
            isend = (i == pulse_bit);
            got_frame[47-i] = cmd_line;
        end
        done_early = done;
        @(negedge clk);
        isend = 1'b0;
        rel_line = cmd_line;
        if (!none) begin
            done_early = done_early | done;
            if (silent) begin
                for (int k = 0; k < NCR; k++) begin
                    isend = pulse_wait && (k == 0);
                    @(negedge clk);
                    done_early = done_early | done;
                end
                isend = 1'b0;
                @(negedge clk);
            end else begin
                for (int k = 0; k < 5; k++) begin
                    isend = pulse_wait && (k == 0);
                    @(negedge clk);
                    done_early = done_early | done;
                end
                isend = 1'b0;
                for (int j = 0; j < 48; j++) begin
                    card_oe = 1'b1;
                    card_bit = rsp[47-j];
                    @(negedge clk);
                    done_early = done_early | done;
                end
                card_oe = 1'b0;
                @(negedge clk);
            end
        end
        done_obs = done; resp_obs = resp; crc_obs = crc_fail; to_obs = timeout;
        @(negedge clk);
        done_after = done;
        pulses = done_cnt - c0;
    endtask

    task automatic test_reset();
        rst = 1'b1; isend = 1'b0; cmd_index = 6'd0; cmd_arg = 32'd0;
        resp_none = 1'b0; resp_nocrc = 1'b0; card_oe = 1'b0; card_bit = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++; if ({resp, crc_fail, timeout, done} !== 35'd0) begin n_fail++; $display("FAIL reset_outputs: got %h expected 0", {resp, crc_fail, timeout, done}); end
        n_checks++; if (cmd_line !== 1'b1) begin n_fail++; $display("FAIL reset_line: got %b expected 1", cmd_line); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset_idle();
        rst = 1'b1;
        #1;
        n_checks++; if ({resp, crc_fail, timeout, done} !== 35'd0) begin n_fail++; $display("FAIL reset_idle: got %h expected 0", {resp, crc_fail, timeout, done}); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_cmd0_no_resp();
        run_txn(6'd0, 32'd0, 1'b1, 1'b0, 1'b0, 48'd0, -1, 1'b0);
        n_checks++; if (got_frame !== 48'h400000000095) begin n_fail++; $display("FAIL cmd0_frame: got %h expected %h", got_frame, 48'h400000000095); end
        n_checks++; if (rel_line !== 1'b1) begin n_fail++; $display("FAIL cmd0_release: got %b expected 1", rel_line); end
        n_checks++; if ({done_early, done_obs, done_after} !== 3'b010) begin n_fail++; $display("FAIL cmd0_done_timing: got %b expected 010", {done_early, done_obs, done_after}); end
        n_checks++; if ({crc_obs, to_obs} !== 2'b00) begin n_fail++; $display("FAIL cmd0_flags: got %b expected 00", {crc_obs, to_obs}); end
    endtask

    task automatic test_cmd8_resp();
        run_txn(6'd8, 32'h000001AA, 1'b0, 1'b0, 1'b0, 48'h08000001AA13, -1, 1'b0);
        n_checks++; if (got_frame !== 48'h48000001AA87) begin n_fail++; $display("FAIL cmd8_frame: got %h expected %h", got_frame, 48'h48000001AA87); end
        n_checks++; if (rel_line !== 1'b1) begin n_fail++; $display("FAIL cmd8_release: got %b expected 1", rel_line); end
        n_checks++; if ({done_early, done_obs, done_after} !== 3'b010) begin n_fail++; $display("FAIL cmd8_done_timing: got %b expected 010", {done_early, done_obs, done_after}); end
        n_checks++; if (resp_obs !== 32'h000001AA) begin n_fail++; $display("FAIL cmd8_resp: got %h expected 000001aa", resp_obs); end
        n_checks++; if ({crc_obs, to_obs} !== 2'b00) begin n_fail++; $display("FAIL cmd8_flags: got %b expected 00", {crc_obs, to_obs}); end
    endtask

    task automatic test_crc_fail();
        // crc field 0x08 instead of 0x09
        run_txn(6'd55, 32'd0, 1'b0, 1'b0, 1'b0, 48'h08000001AA11, -1, 1'b0);
        n_checks++; if (got_frame !== 48'h770000000065) begin n_fail++; $display("FAIL cmd55_frame: got %h expected %h", got_frame, 48'h770000000065); end
        n_checks++; if ({crc_obs, to_obs, done_obs} !== 3'b101) begin n_fail++; $display("FAIL cmd55_badcrc: got %b expected 101", {crc_obs, to_obs, done_obs}); end
        n_checks++; if (crc_fail !== 1'b1 || resp !== 32'h000001AA) begin n_fail++; $display("FAIL cmd55_hold: got %b %h expected 1 000001aa", crc_fail, resp); end
        test_reset_idle();
    endtask

    task automatic test_nocrc();
        run_txn(6'd55, 32'd0, 1'b0, 1'b1, 1'b0, 48'h08000001AA11, -1, 1'b0);
        n_checks++; if ({crc_obs, done_obs} !== 2'b01) begin n_fail++; $display("FAIL nocrc_flag: got %b expected 01", {crc_obs, done_obs}); end
        n_checks++; if (resp_obs !== 32'h000001AA) begin n_fail++; $display("FAIL nocrc_resp: got %h expected 000001aa", resp_obs); end
    endtask

    task automatic test_framing();
        run_txn(6'd8, 32'h000001AA, 1'b0, 1'b1, 1'b0, 48'h48000001AA13, -1, 1'b0);
        n_checks++; if (crc_obs !== 1'b1) begin n_fail++; $display("FAIL frame_trans_bit: got %b expected 1", crc_obs); end
        run_txn(6'd8, 32'h000001AA, 1'b0, 1'b0, 1'b0, 48'h08000001AA12, -1, 1'b0);
        n_checks++; if (crc_obs !== 1'b1) begin n_fail++; $display("FAIL frame_end_bit: got %b expected 1", crc_obs); end
        run_txn(6'd8, 32'h000001AA, 1'b0, 1'b0, 1'b0, 48'h08000001AA13, -1, 1'b0);
        n_checks++; if (crc_obs !== 1'b0) begin n_fail++; $display("FAIL frame_clear_on_send: got %b expected 0", crc_obs); end
    endtask

    task automatic test_timeout();
        run_txn(6'd8, 32'h000001AA, 1'b0, 1'b0, 1'b1, 48'd0, -1, 1'b0);
        n_checks++; if ({done_early, done_obs, done_after} !== 3'b010) begin n_fail++; $display("FAIL timeout_done_timing: got %b expected 010", {done_early, done_obs, done_after}); end
        n_checks++; if ({to_obs, crc_obs} !== 2'b10) begin n_fail++; $display("FAIL timeout_flags: got %b expected 10", {to_obs, crc_obs}); end
        n_checks++; if (resp_obs !== 32'd0) begin n_fail++; $display("FAIL timeout_resp: got %h expected 0", resp_obs); end
        test_reset_idle();
    endtask

    task automatic test_reset_mid_send();
        @(negedge clk);
        cmd_index = 6'd8; cmd_arg = 32'h000001AA; resp_none = 1'b0; resp_nocrc = 1'b0; isend = 1'b1;
        @(posedge clk);
        for (int i = 0; i <= 20; i++) begin
            @(negedge clk);
            isend = 1'b0;
        end
        n_checks++; if (cmd_line !== 1'b0) begin n_fail++; $display("FAIL rst_mid_bit20: got %b expected 0", cmd_line); end
        rst = 1'b1;
        #1;
        n_checks++; if (cmd_line !== 1'b1) begin n_fail++; $display("FAIL rst_mid_release: got %b expected 1", cmd_line); end
        n_checks++; if ({resp, crc_fail, timeout, done} !== 35'd0) begin n_fail++; $display("FAIL rst_mid_outputs: got %h expected 0", {resp, crc_fail, timeout, done}); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_txn(6'd0, 32'd0, 1'b1, 1'b0, 1'b0, 48'd0, -1, 1'b0);
        n_checks++; if (got_frame !== 48'h400000000095) begin n_fail++; $display("FAIL rst_mid_refresh_frame: got %h expected %h", got_frame, 48'h400000000095); end
        n_checks++; if (done_obs !== 1'b1) begin n_fail++; $display("FAIL rst_mid_refresh_done: got %b expected 1", done_obs); end
    endtask

    task automatic test_isend_ignored();
        int c0;
        logic idle_ok;
        run_txn(6'd8, 32'h000001AA, 1'b0, 1'b0, 1'b0, 48'h08000001AA13, 10, 1'b1);
        n_checks++; if (got_frame !== 48'h48000001AA87) begin n_fail++; $display("FAIL ignore_frame: got %h expected %h", got_frame, 48'h48000001AA87); end
        n_checks++; if (pulses !== 1) begin n_fail++; $display("FAIL ignore_done_pulses: got %0d expected 1", pulses); end
        n_checks++; if (resp_obs !== 32'h000001AA || crc_obs !== 1'b0) begin n_fail++; $display("FAIL ignore_resp: got %h %b expected 000001aa 0", resp_obs, crc_obs); end
        c0 = done_cnt;
        idle_ok = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (cmd_line !== 1'b1) idle_ok = 1'b0;
        end
        n_checks++; if (idle_ok !== 1'b1 || done_cnt != c0) begin n_fail++; $display("FAIL ignore_no_second_frame: got %b/%0d expected 1/0", idle_ok, done_cnt - c0); end
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        cmd_index = 6'd0; cmd_arg = 32'd0; resp_none = 1'b1; resp_nocrc = 1'b0; isend = 1'b1;
        @(posedge clk);
        for (int i = 0; i < 48; i++) begin
            @(negedge clk);
            got_frame[47-i] = cmd_line;
        end
        n_checks++; if (got_frame !== 48'h400000000095) begin n_fail++; $display("FAIL b2b_frame: got %h expected %h", got_frame, 48'h400000000095); end
        @(negedge clk);
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL b2b_done: got %b expected 1", done); end
        @(negedge clk);
        n_checks++; if ({cmd_line, done} !== 2'b10) begin n_fail++; $display("FAIL b2b_idle_gap: got %b expected 10", {cmd_line, done}); end
        @(negedge clk);
        isend = 1'b0;
        n_checks++; if (cmd_line !== 1'b0) begin n_fail++; $display("FAIL b2b_restart_start_bit: got %b expected 0", cmd_line); end
        @(negedge clk);
        n_checks++; if (cmd_line !== 1'b1) begin n_fail++; $display("FAIL b2b_restart_trans_bit: got %b expected 1", cmd_line); end
        repeat (52) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_cmd0_no_resp();
        test_cmd8_resp();
        test_crc_fail();
        test_nocrc();
        test_framing();
        test_timeout();
        test_reset_mid_send();
        test_isend_ignored();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
